vga_pixel_gen_scaled: RTL and testbench

//  Upscaling framebuffer pixel generator: maps the active raster onto an IMG_W x IMG_H RGB image in an external sync ROM/RAM,

---
 rtl/vga_pixel_gen_pkg.sv | 23 ++
 rtl/vga_pipe_delay.sv | 25 ++
 rtl/vga_pixel_gen_scaled.sv | 145 ++++++++++++++
 tb/tb_vga_pixel_gen_scaled.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pixel_gen_pkg.sv
// Shared types and helpers for the scaled VGA pixel generator.
package vga_pixel_gen_pkg;

    typedef enum logic [1:0] {
        PX_BLANK  = 2'd0,
        PX_BORDER = 2'd1,
        PX_IMAGE  = 2'd2
    } pixel_class_t;

    localparam int unsigned RGB_CH_W = 8;

    typedef struct packed {
        logic [RGB_CH_W-1:0] r;
        logic [RGB_CH_W-1:0] g;
        logic [RGB_CH_W-1:0] b;
    } rgb_t;

    // Address the memory port sits on when no image pixel is being fetched.
    function automatic logic [31:0] park_addr(input int unsigned addr_w);
        return (addr_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << addr_w) - 32'd1);
    endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// Fixed-depth shift register; keeps side-band flags aligned with a memory read.
module vga_pipe_delay #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_gen_scaled.sv
// Upscaling framebuffer pixel generator: each image pixel covers 2^SCALE_SHIFT squared raster pixels.
// Define PIXEL_GEN_SCROLL_EN to add toroidal scroll_x/scroll_y image offsets.
module vga_pixel_gen_scaled
    import vga_pixel_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 1280,
    parameter int unsigned V_ACTIVE    = 720,
    parameter int unsigned IMG_W       = 320,
    parameter int unsigned IMG_H       = 180,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned COLOR_W     = 8,
    parameter int unsigned ROM_LATENCY = 1,
    parameter logic [3*COLOR_W-1:0] BORDER_RGB = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [11:0]          h_counter,
    input  logic [11:0]          v_counter,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [3*COLOR_W-1:0] rom_q,
    output logic [COLOR_W-1:0]   vga_r,
    output logic [COLOR_W-1:0]   vga_g,
    output logic [COLOR_W-1:0]   vga_b,
    output logic                 vga_de
`ifdef PIXEL_GEN_SCROLL_EN
    ,
    input  logic [8:0]           scroll_x,
    input  logic [7:0]           scroll_y
`endif
);

    localparam int unsigned PIPE_LAT = ROM_LATENCY + 2;
    localparam logic [ADDR_W-1:0] PARK = ADDR_W'(park_addr(ADDR_W));
    localparam logic [11:0] H_ACT = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT = 12'(V_ACTIVE);
    localparam logic [11:0] IMG_H_R = 12'(IMG_H);
    localparam logic [12:0] IMG_W_X = 13'(IMG_W);
    localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);
    localparam int unsigned SUB_W = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'((1 << SCALE_SHIFT) - 1);

    logic [11:0]       img_x, row;
    logic [12:0]       x_sum, x_wrapped;
    pixel_class_t      cls_s0, cls_q;
    logic [ADDR_W-1:0] x_q;
    logic [ADDR_W-1:0] line_base_q, base_next, base_preload;
    logic [SUB_W-1:0]  sub_y_q;
    logic [8:0]        sx_q;
    logic [1:0]        cls_dly;

`ifdef PIXEL_GEN_SCROLL_EN
    localparam logic [ADDR_W:0] IMG_SIZE = {1'b0, ADDR_W'(IMG_W * IMG_H)};
    logic [7:0] sy_q;

    // Offsets are captured once per frame at the start of vblank.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sx_q <= '0;
            sy_q <= '0;
        end else if (v_counter == V_ACT && h_counter == 12'd0) begin
            sx_q <= (32'(scroll_x) < IMG_W) ? scroll_x : '0;
            sy_q <= (32'(scroll_y) < IMG_H) ? scroll_y : '0;
        end
    end

    assign base_preload = ADDR_W'(32'(sy_q) * IMG_W);
    assign base_next    = (({1'b0, line_base_q} + {1'b0, IMG_W_A}) >= IMG_SIZE) ? '0
                                                                               : line_base_q + IMG_W_A;
`else
    assign sx_q         = '0;
    assign base_preload = '0;
    assign base_next    = line_base_q + IMG_W_A;
`endif

    always_comb begin
        img_x  = h_counter >> SCALE_SHIFT;
        row    = v_counter >> SCALE_SHIFT;
        cls_s0 = PX_BLANK;
        if (h_counter < H_ACT && v_counter < V_ACT) begin
            cls_s0 = (({1'b0, img_x} < IMG_W_X) && (row < IMG_H_R)) ? PX_IMAGE : PX_BORDER;
        end
        x_sum     = {1'b0, img_x} + {4'b0, sx_q};
        x_wrapped = (x_sum >= IMG_W_X) ? x_sum - IMG_W_X : x_sum;
    end

    // Row base advances by IMG_W once every 2^SCALE_SHIFT raster lines; no per-pixel multiply.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sub_y_q     <= '0;
            line_base_q <= '0;
        end else if (v_counter >= V_ACT) begin
            sub_y_q     <= '0;
            line_base_q <= base_preload;
        end else if (h_counter == H_ACT) begin
            sub_y_q <= sub_y_q + 1'b1;
            if (sub_y_q == SUB_LAST) line_base_q <= base_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cls_q    <= PX_BLANK;
            x_q      <= '0;
            rom_addr <= PARK;
        end else begin
            cls_q    <= cls_s0;
            x_q      <= ADDR_W'(x_wrapped);
            rom_addr <= (cls_q == PX_IMAGE) ? line_base_q + x_q : PARK;
        end
    end

    vga_pipe_delay #(
        .DEPTH(PIPE_LAT - 1),
        .WIDTH(2)
    ) u_cls_delay (
        .clk (clk),
        .rst (rst),
        .din (cls_q),
        .dout(cls_dly)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            {vga_r, vga_g, vga_b} <= '0;
            vga_de                <= 1'b0;
        end else begin
            case (pixel_class_t'(cls_dly))
                PX_IMAGE: begin
                    {vga_r, vga_g, vga_b} <= rom_q;
                    vga_de                <= 1'b1;
                end
                PX_BORDER: begin
                    {vga_r, vga_g, vga_b} <= BORDER_RGB;
                    vga_de                <= 1'b1;
                end
                default: begin
                    {vga_r, vga_g, vga_b} <= '0;
                    vga_de                <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_pixel_gen_scaled.sv
// Bench for vga_pixel_gen_scaled: sparse randomized raster scans against a frame-level model.
// Two instances (IMG_W 320 and 300); PIXEL_GEN_SCROLL_EN adds scroll frames.
module tb_vga_pixel_gen_scaled;
    import vga_pixel_gen_pkg::*;

    localparam int MAXC = 24000;
    localparam int PARK = 65535;
    localparam logic [23:0] BORDER_A = 24'hA5C33C;
    localparam logic [23:0] BORDER_B = 24'h123456;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [11:0]      h_cnt, v_cnt;
    logic [1:0][15:0] addr_w;
    logic [1:0][23:0] q_w;
    logic [1:0][23:0] rgb_w;
    logic [1:0]       de_w;
`ifdef PIXEL_GEN_SCROLL_EN
    logic [8:0]       sx_drv;
    logic [7:0]       sy_drv;
`endif

    int total, bad, edge_n;
    int s_cls    [2][MAXC];
    int s_addr   [2][MAXC];
    bit s_chk    [2][MAXC];
    int lit_addr [2][MAXC];
    int lit_out  [2][MAXC];
    bit s_rst    [MAXC];
    bit frame_ok;
    int sx_m [2];
    int sy_m [2];
    int img_w [2];
    int border [2];

    always #5 clk = ~clk;

    vga_pixel_gen_scaled #(
        .BORDER_RGB(BORDER_A)
    ) u_dut_a (
        .clk      (clk),
        .rst      (rst_n),
        .h_counter(h_cnt),
        .v_counter(v_cnt),
        .rom_addr (addr_w[0]),
        .rom_q    (q_w[0]),
        .vga_r    (rgb_w[0][23:16]),
        .vga_g    (rgb_w[0][15:8]),
        .vga_b    (rgb_w[0][7:0]),
        .vga_de   (de_w[0])
`ifdef PIXEL_GEN_SCROLL_EN
        ,
        .scroll_x (sx_drv),
        .scroll_y (sy_drv)
`endif
    );

    vga_pixel_gen_scaled #(
        .IMG_W     (300),
        .BORDER_RGB(BORDER_B)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst_n),
        .h_counter(h_cnt),
        .v_counter(v_cnt),
        .rom_addr (addr_w[1]),
        .rom_q    (q_w[1]),
        .vga_r    (rgb_w[1][23:16]),
        .vga_g    (rgb_w[1][15:8]),
        .vga_b    (rgb_w[1][7:0]),
        .vga_de   (de_w[1])
`ifdef PIXEL_GEN_SCROLL_EN
        ,
        .scroll_x (sx_drv),
        .scroll_y (sy_drv)
`endif
    );

    function automatic rgb_t rom_word(input logic [15:0] a);
        rgb_t w;
        w.r = a[7:0] ^ 8'h3C;
        w.g = a[15:8] + 8'd17;
        w.b = a[7:0] + a[15:8];
        return w;
    endfunction

    // One-cycle synchronous ROM per instance.
    always @(posedge clk) begin
        q_w[0] <= rom_word(addr_w[0]);
        q_w[1] <= rom_word(addr_w[1]);
    end

    // 0 blank, 1 border, 2 image
    function automatic int m_cls(input int h, input int v, input int w);
        if (h >= 1280 || v >= 720) return 0;
        if ((h >> 2) < w && (v >> 2) < 180) return 2;
        return 1;
    endfunction

    function automatic int m_addr(input int h, input int v, input int w, input int sx, input int sy);
        return (((v >> 2) + sy) % 180) * w + ((h >> 2) + sx) % w;
    endfunction

    function automatic void chk(input string nm, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d edge %0d: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, idx, edge_n, act, act, exp, exp);
        end
    endfunction

    task automatic step(input int h, input int v, input bit r);
        int e;
        e = edge_n + 1;
        if (e >= MAXC) begin
            $display("FAIL bench_capacity edge %0d exceeds %0d", e, MAXC);
            $fatal(1);
        end
        h_cnt    = 12'(h);
        v_cnt    = 12'(v);
        rst_n    = r;
        s_rst[e] = !r;
        for (int i = 0; i < 2; i++) begin
            lit_addr[i][e] = -1;
            lit_out[i][e]  = -1;
            if (!r) begin
                // reset flushes every class flag still in flight
                s_cls[i][e] = 0;
                s_chk[i][e] = 1'b0;
                if (e > 1) s_cls[i][e-1] = 0;
                if (e > 2) s_cls[i][e-2] = 0;
            end else begin
                s_cls[i][e]  = m_cls(h, v, img_w[i]);
                s_addr[i][e] = m_addr(h, v, img_w[i], sx_m[i], sy_m[i]);
                s_chk[i][e]  = frame_ok;
            end
        end
        if (!r) begin
            frame_ok = 1'b0;
            sx_m = '{0, 0};
            sy_m = '{0, 0};
        end else if (v >= 720) begin
            frame_ok = 1'b1;
`ifdef PIXEL_GEN_SCROLL_EN
            if (v == 720 && h == 0) begin
                for (int i = 0; i < 2; i++) begin
                    sx_m[i] = (int'(sx_drv) < img_w[i]) ? int'(sx_drv) : 0;
                    sy_m[i] = (int'(sy_drv) < 180) ? int'(sy_drv) : 0;
                end
            end
`endif
        end
        @(posedge clk);
        edge_n = e;
        #1;
    endtask

    // mode 1: plain directed points; 2..4: scroll directed points; 0: random only
    task automatic run_frame(input int mode, input int rst_line);
        int h;
        step(0, 720, 1);
        step(1, 720, 1);
        step(3, 741, 1);
        for (int v = 0; v < 720; v++) begin
            if (v == 0 && mode == 1) begin
                step(0, 0, 1);    lit_addr[0][edge_n] = 0;
                step(4, 0, 1);    lit_addr[0][edge_n] = 1;
                step(1200, 0, 1); lit_out[1][edge_n]  = int'(BORDER_B);
                step(1196, 0, 1); lit_addr[1][edge_n] = 299;
            end
            if (v == 4 && mode == 1) begin step(0, 4, 1); lit_addr[0][edge_n] = 320; end
            if (v == 719 && mode == 1) begin step(1279, 719, 1); lit_addr[0][edge_n] = 57599; end
            if (v == 0 && mode == 2) begin step(0, 0, 1); lit_addr[0][edge_n] = 650; end
            if (v == 0 && mode == 3) begin step(4, 0, 1); lit_addr[0][edge_n] = 0; end
            if (v == 4 && mode == 4) begin step(0, 4, 1); lit_addr[0][edge_n] = 0; end
            for (int k = 0; k < 3; k++) begin
                h = int'($urandom_range(1599, 0));
                if (h == 1280) h = 1279;
                step(h, v, 1);
            end
            if (v == rst_line) step(640, v, 0);
            step(1280, v, 1);
        end
    endtask

    always @(negedge clk) begin
        int m, c;
        m = edge_n;
        if (m >= 1) begin
            for (int i = 0; i < 2; i++) begin
                if (s_rst[m]) begin
                    chk("rst_addr", i, int'(addr_w[i]), PARK);
                    chk("rst_rgb", i, int'(rgb_w[i]), 0);
                    chk("rst_de", i, int'(de_w[i]), 0);
                end else begin
                    if (m >= 2) begin
                        c = s_cls[i][m-1];
                        if (c != 2) chk("addr_park", i, int'(addr_w[i]), PARK);
                        else if (s_chk[i][m-1]) chk("addr", i, int'(addr_w[i]), s_addr[i][m-1]);
                        if (lit_addr[i][m-1] >= 0)
                            chk("addr_lit", i, int'(addr_w[i]), lit_addr[i][m-1]);
                    end
                    if (m >= 4) begin
                        c = s_cls[i][m-3];
                        chk("de", i, int'(de_w[i]), (c != 0) ? 1 : 0);
                        if (c == 0) chk("rgb_blank", i, int'(rgb_w[i]), 0);
                        else if (c == 1) chk("rgb_border", i, int'(rgb_w[i]), border[i]);
                        else if (s_chk[i][m-3])
                            chk("rgb_image", i, int'(rgb_w[i]),
                                int'(rom_word(16'(s_addr[i][m-3]))));
                        if (lit_out[i][m-3] >= 0)
                            chk("rgb_lit", i, int'(rgb_w[i]), lit_out[i][m-3]);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at edge %0d", edge_n);
        $fatal(1);
    end

    initial begin
        total    = 0;
        bad      = 0;
        edge_n   = 0;
        frame_ok = 1'b0;
        sx_m     = '{0, 0};
        sy_m     = '{0, 0};
        img_w    = '{320, 300};
        border   = '{int'(BORDER_A), int'(BORDER_B)};
        rst_n    = 1'b0;
        h_cnt    = '0;
        v_cnt    = '0;
`ifdef PIXEL_GEN_SCROLL_EN
        sx_drv   = '0;
        sy_drv   = '0;
`endif
        // hand-computed anchors for the model
        chk("pin_addr_0_4", 0, m_addr(0, 4, 320, 0, 0), 320);
        chk("pin_addr_last", 0, m_addr(1279, 719, 320, 0, 0), 57599);
        chk("pin_addr_scroll", 0, m_addr(0, 0, 320, 10, 2), 650);
        chk("pin_cls_border", 1, m_cls(1200, 0, 300), 1);

        for (int k = 0; k < 10; k++) step(k * 37, 300, 0);
        run_frame(1, -1);
        run_frame(0, 100);
        run_frame(1, -1);
`ifdef PIXEL_GEN_SCROLL_EN
        sx_drv = 9'd10;  sy_drv = 8'd2;   run_frame(2, -1);
        sx_drv = 9'd319; sy_drv = 8'd0;   run_frame(3, -1);
        sx_drv = 9'd400; sy_drv = 8'd179; run_frame(4, -1);
`endif
        for (int k = 0; k < 4; k++) step(k, 730, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
